// File: rtl/lantian_phy_poller.sv
// lantian_phy_poller: Avalon-MM master that polls PHY BMSR/PHYSR through the MDIO slave and
// publishes link/speed/duplex/autoneg sideband. Define PHY_POLLER_INIT_EN for a one-shot BMCR write.

module lantian_phy_poller #(
   parameter logic [31:0] POLL_INTERVAL = 32'd5_000_000,
   parameter logic [4:0]  PHYSR_ADDR    = 5'd17,
   parameter int unsigned TIMEOUT       = 4096,
   parameter logic [15:0] BMCR_INIT     = 16'h1200
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [4:0]  mdio_address,
   output logic        mdio_read,
   output logic        mdio_write,
   output logic [31:0] mdio_writedata,
   input  logic [31:0] mdio_readdata,
   input  logic        mdio_waitrequest,
   output logic        link_up,
   output logic [1:0]  speed,
   output logic        full_duplex,
   output logic        an_done,
   output logic        status_valid,
   output logic        link_change,
   output logic        mdio_error
);

   localparam logic [4:0]      BMSR_ADDR = 5'd1;
   localparam int              TO_W      = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
   localparam logic [31:0]     WAIT_LAST = POLL_INTERVAL - 32'd1;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_RD_BMSR,
      ST_GAP,
      ST_RD_PHYSR,
      ST_UPDATE
`ifdef PHY_POLLER_INIT_EN
      , ST_INIT_WR
`endif
   } state_t;

`ifdef PHY_POLLER_INIT_EN
   localparam state_t RESET_STATE = ST_INIT_WR;
`else
   localparam state_t RESET_STATE = ST_WAIT;
`endif

   state_t          state, next_state;
   logic [31:0]     timer;
   logic [TO_W-1:0] to_cnt;
   logic            in_txn;
   logic            txn_done;
   logic            txn_expired;
   logic            cap_an, cap_link, cap_resolved, cap_duplex;
   logic [1:0]      cap_speed;
   logic            new_link;
   logic            readdata_unused;

   assign readdata_unused = &{1'b0, mdio_readdata[31:16], mdio_readdata[12],
                              mdio_readdata[9:6], mdio_readdata[4:0]};

   assign txn_done    = in_txn && !mdio_waitrequest;
   assign txn_expired = in_txn && mdio_waitrequest && (to_cnt == TO_LAST);
   assign new_link    = cap_link && cap_resolved;

`ifdef PHY_POLLER_INIT_EN
   // Reset parks the FSM in INIT_WR, so the write strobe is gated to stay low while reset holds.
   assign mdio_write     = reset_n && (state == ST_INIT_WR);
   assign mdio_writedata = mdio_write ? {16'h0000, BMCR_INIT} : 32'h0000_0000;
`else
   assign mdio_write     = 1'b0;
   assign mdio_writedata = 32'h0000_0000;
`endif

   always_comb begin
      next_state   = state;
      in_txn       = 1'b0;
      mdio_read    = 1'b0;
      mdio_address = 5'd0;
      case (state)
         ST_WAIT: begin
            if (timer == WAIT_LAST) next_state = ST_RD_BMSR;
         end
         ST_RD_BMSR: begin
            in_txn       = 1'b1;
            mdio_read    = 1'b1;
            mdio_address = BMSR_ADDR;
            if (!mdio_waitrequest)        next_state = ST_GAP;
            else if (to_cnt == TO_LAST)   next_state = ST_WAIT;
         end
         ST_GAP: begin
            next_state = ST_RD_PHYSR;
         end
         ST_RD_PHYSR: begin
            in_txn       = 1'b1;
            mdio_read    = 1'b1;
            mdio_address = PHYSR_ADDR;
            if (!mdio_waitrequest)        next_state = ST_UPDATE;
            else if (to_cnt == TO_LAST)   next_state = ST_WAIT;
         end
         ST_UPDATE: begin
            next_state = ST_WAIT;
         end
`ifdef PHY_POLLER_INIT_EN
         ST_INIT_WR: begin
            in_txn = 1'b1;
            if (!mdio_waitrequest || (to_cnt == TO_LAST)) next_state = ST_WAIT;
         end
`endif
         default: begin
            next_state = ST_WAIT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= RESET_STATE;
      else          state <= next_state;
   end

   // Poll timer restarts from zero on every WAIT entry, so the interval is measured end-to-start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                    timer <= 32'd0;
      else if ((state == ST_WAIT) && (timer != WAIT_LAST)) timer <= timer + 32'd1;
      else                                             timer <= 32'd0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                           to_cnt <= '0;
      else if (in_txn && mdio_waitrequest && (to_cnt != TO_LAST)) to_cnt <= to_cnt + 1'b1;
      else                                                    to_cnt <= '0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cap_an       <= 1'b0;
         cap_link     <= 1'b0;
         cap_resolved <= 1'b0;
         cap_duplex   <= 1'b0;
         cap_speed    <= 2'b00;
      end else begin
         if ((state == ST_RD_BMSR) && txn_done) cap_an <= mdio_readdata[5];
         if ((state == ST_RD_PHYSR) && txn_done) begin
            cap_speed    <= mdio_readdata[15:14];
            cap_duplex   <= mdio_readdata[13];
            cap_resolved <= mdio_readdata[11];
            cap_link     <= mdio_readdata[10];
         end
      end
   end

   // Sideband outputs change only in UPDATE; a timed-out poll never reaches it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         link_up      <= 1'b0;
         speed        <= 2'b00;
         full_duplex  <= 1'b0;
         an_done      <= 1'b0;
         status_valid <= 1'b0;
         link_change  <= 1'b0;
         mdio_error   <= 1'b0;
      end else begin
         link_change <= 1'b0;
         if (txn_expired) mdio_error <= 1'b1;
         if (state == ST_UPDATE) begin
            link_up      <= new_link;
            link_change  <= (new_link != link_up);
            speed        <= cap_speed;
            full_duplex  <= cap_duplex;
            an_done      <= cap_an;
            status_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lantian_phy_poller.sv
// tb_lantian_phy_poller: directed + randomized polls against an MDIO slave model, checked
// against a behavioural model of the PHY status decoding and poll timing.

module tb_lantian_phy_poller;

   localparam int         POLL    = 100;
   localparam int         TMO     = 4096;
   localparam logic [4:0] PHYSR_A = 5'd17;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [4:0]  mdio_address;
   logic        mdio_read;
   logic        mdio_write;
   logic [31:0] mdio_writedata;
   logic [31:0] mdio_readdata;
   logic        mdio_waitrequest;
   logic        link_up;
   logic [1:0]  speed;
   logic        full_duplex;
   logic        an_done;
   logic        status_valid;
   logic        link_change;
   logic        mdio_error;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          wait_cfg  = 0;
   logic [15:0] bmsr_val  = 16'h0;
   logic [15:0] physr_val = 16'h0;
   int          bfm_cnt   = 0;

   int          write_count     = 0;
   int          conflicts       = 0;
   int          wd_bad          = 0;
   int          addr_unstable   = 0;
   int          last_bmsr_start = 0;
   int          last_gap        = 0;
   int          last_rd_len     = 0;
   logic [4:0]  first_wr_addr   = 5'h1f;
   logic [31:0] first_wr_data   = 32'hffff_ffff;

   logic       exp_link, exp_dup, exp_an, exp_valid, exp_error;
   logic [1:0] exp_speed;
   int         prev_start, prev_w, rel_cyc;
   bit         have_prev;

   lantian_phy_poller #(
      .POLL_INTERVAL (32'(POLL)),
      .PHYSR_ADDR    (PHYSR_A),
      .TIMEOUT       (TMO),
      .BMCR_INIT     (16'h1200)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .mdio_address     (mdio_address),
      .mdio_read        (mdio_read),
      .mdio_write       (mdio_write),
      .mdio_writedata   (mdio_writedata),
      .mdio_readdata    (mdio_readdata),
      .mdio_waitrequest (mdio_waitrequest),
      .link_up          (link_up),
      .speed            (speed),
      .full_duplex      (full_duplex),
      .an_done          (an_done),
      .status_valid     (status_valid),
      .link_change      (link_change),
      .mdio_error       (mdio_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // MDIO slave model: waitrequest drops after wait_cfg strobe cycles, garbage in the upper half.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n)                     bfm_cnt <= 0;
      else if (mdio_read || mdio_write) bfm_cnt <= bfm_cnt + 1;
      else                              bfm_cnt <= 0;
   end

   assign mdio_waitrequest = !((mdio_read || mdio_write) && (bfm_cnt == wait_cfg));

   always_comb begin
      mdio_readdata = 32'hffff_ffff;
      if (mdio_address == 5'd1)         mdio_readdata = {16'hbeef, bmsr_val};
      else if (mdio_address == PHYSR_A) mdio_readdata = {16'hc0de, physr_val};
   end

   // Bus monitor: records strobe timing and protocol violations for the main sequence.
   initial begin : monitor
      logic       prev_rd, prev_wr;
      int         low_run, rd_len;
      logic [4:0] start_addr;
      prev_rd = 1'b0; prev_wr = 1'b0; low_run = 0; rd_len = 0; start_addr = 5'd0;
      forever begin
         @(negedge clk);
         if (mdio_read && mdio_write) conflicts++;
         if (mdio_write && !prev_wr) begin
            write_count++;
            if (write_count == 1) begin
               first_wr_addr = mdio_address;
               first_wr_data = mdio_writedata;
            end
         end
`ifndef PHY_POLLER_INIT_EN
         if (mdio_writedata != 32'h0) wd_bad++;
`endif
         if (mdio_read) begin
            if (!prev_rd) begin
               rd_len     = 1;
               start_addr = mdio_address;
               if (mdio_address == 5'd1) last_bmsr_start = cyc;
               else                      last_gap        = low_run;
            end else begin
               rd_len++;
               if (mdio_address != start_addr) addr_unstable++;
            end
            low_run = 0;
         end else begin
            if (prev_rd) last_rd_len = rd_len;
            low_run++;
         end
         prev_rd = mdio_read;
         prev_wr = mdio_write;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] b, input logic [15:0] p, input int w);
      bmsr_val  = b;
      physr_val = p;
      wait_cfg  = w;
   endtask

   task automatic modelReset();
      exp_link = 1'b0; exp_dup = 1'b0; exp_an = 1'b0; exp_valid = 1'b0; exp_error = 1'b0;
      exp_speed = 2'b00;
      have_prev = 1'b0;
   endtask

   task automatic checkSideband(input string tag);
      checkOutput({tag, "_link"},   32'(link_up),      32'(exp_link));
      checkOutput({tag, "_speed"},  32'(speed),        32'(exp_speed));
      checkOutput({tag, "_duplex"}, 32'(full_duplex),  32'(exp_dup));
      checkOutput({tag, "_an"},     32'(an_done),      32'(exp_an));
      checkOutput({tag, "_valid"},  32'(status_valid), 32'(exp_valid));
      checkOutput({tag, "_error"},  32'(mdio_error),   32'(exp_error));
   endtask

   // mode 0: no start-time check, 1: interval from previous poll, 2: first poll after reset.
   task automatic runPoll(input logic [15:0] b, input logic [15:0] p, input int w, input int mode);
      int   n, exp_start;
      logic seen, nl, exp_change;
      applyStimulus(b, p, w);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         seen = mdio_read && (mdio_address == PHYSR_A) && !mdio_waitrequest;
      end while (!seen && n < 400);
      checkOutput("poll_seen", 32'(seen), 32'd1);
      checkOutput("hold_link", 32'(link_up), 32'(exp_link));
      checkOutput("hold_speed", 32'(speed), 32'(exp_speed));
      checkOutput("gap_cycles", 32'(last_gap), 32'd1);
      if (mode == 1) begin
         checkOutput("interval", 32'(last_bmsr_start - prev_start), 32'(POLL + 2 * (prev_w + 1) + 2));
      end else if (mode == 2) begin
`ifdef PHY_POLLER_INIT_EN
         exp_start = POLL + w + 1;
`else
         exp_start = POLL;
`endif
         checkOutput("first_start", 32'(last_bmsr_start - rel_cyc), 32'(exp_start));
      end
      prev_start = last_bmsr_start;
      prev_w     = w;
      have_prev  = 1'b1;
      nl         = p[10] & p[11];
      exp_change = (nl != exp_link);
      exp_link   = nl;
      exp_speed  = p[15:14];
      exp_dup    = p[13];
      exp_an     = b[5];
      exp_valid  = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checkSideband("poll");
      checkOutput("link_change", 32'(link_change), 32'(exp_change));
      checkOutput("rd_len", 32'(last_rd_len), 32'(w + 1));
      @(negedge clk);
      checkOutput("link_change_end", 32'(link_change), 32'd0);
   endtask

   initial begin
      int n;
      modelReset();
      prev_start = 0; prev_w = 0; rel_cyc = 0;
      reset_n = 1'b0;
      applyStimulus(16'h0024, 16'hac00, 10);
      repeat (3) @(negedge clk);
      checkSideband("rst");
      checkOutput("rst_link_change", 32'(link_change), 32'd0);
      checkOutput("rst_read", 32'(mdio_read), 32'd0);
      checkOutput("rst_write", 32'(mdio_write), 32'd0);
      checkOutput("rst_addr", 32'(mdio_address), 32'd0);
      checkOutput("rst_wdata", mdio_writedata, 32'd0);
      reset_n = 1'b1;
      rel_cyc = cyc;

      runPoll(16'h0024, 16'hac00, 10, 2);
`ifdef PHY_POLLER_INIT_EN
      checkOutput("init_wr_count", 32'(write_count), 32'd1);
      checkOutput("init_wr_addr", 32'(first_wr_addr), 32'd0);
      checkOutput("init_wr_data", first_wr_data, 32'h0000_1200);
`else
      checkOutput("no_write", 32'(write_count), 32'd0);
`endif
      runPoll(16'h0024, 16'hac00, 10, 1);

      for (int i = 0; i < 6; i++) begin
         runPoll(16'($urandom), 16'($urandom), int'($urandom_range(0, 12)), 1);
      end

      runPoll(16'h0000, 16'h0400, 2, 1);
      runPoll(16'h0024, 16'hac00, 0, 1);
      runPoll(16'h0000, 16'h0000, 5, 1);
      runPoll(16'h0000, 16'h0000, 5, 1);
      runPoll(16'h0020, 16'hec00, 7, 1);
`ifdef PHY_POLLER_INIT_EN
      checkOutput("write_once", 32'(write_count), 32'd1);
`endif

      applyStimulus(16'h0000, 16'h0000, 5000);
      n = 0;
      do begin @(negedge clk); n++; end while (!mdio_read && n < 300);
      n = 0;
      do begin @(negedge clk); n++; end while (mdio_read && n < 6000);
      @(negedge clk);
      exp_error = 1'b1;
      have_prev = 1'b0;
      checkOutput("to_len", 32'(last_rd_len), 32'(TMO));
      checkSideband("to");
      checkOutput("to_link_change", 32'(link_change), 32'd0);

      runPoll(16'h0024, 16'hac00, 3, 0);

      applyStimulus(16'h0020, 16'h6c00, 20);
      n = 0;
      do begin @(negedge clk); n++; end while (!(mdio_read && mdio_address == PHYSR_A) && n < 400);
      checkOutput("physr_seen", 32'(mdio_read), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      modelReset();
      checkOutput("arst_read", 32'(mdio_read), 32'd0);
      checkOutput("arst_write", 32'(mdio_write), 32'd0);
      checkOutput("arst_addr", 32'(mdio_address), 32'd0);
      checkOutput("arst_link_change", 32'(link_change), 32'd0);
      checkSideband("arst");
      applyStimulus(16'h0020, 16'h6c00, 4);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      rel_cyc = cyc;
      runPoll(16'h0020, 16'h6c00, 4, 2);

`ifdef PHY_POLLER_INIT_EN
      checkOutput("write_total", 32'(write_count), 32'd2);
`else
      checkOutput("write_total", 32'(write_count), 32'd0);
      checkOutput("wdata_zero", 32'(wd_bad), 32'd0);
`endif
      checkOutput("strobe_conflict", 32'(conflicts), 32'd0);
      checkOutput("addr_stable", 32'(addr_unstable), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
